// File: rtl/nibble_demux_pkg.sv
// Shared types and constants for the nibble demux accumulator.
// Lane geometry, FSM states and the word reset value.
package nibble_demux_pkg;
  localparam int NIB_W  = 4;
  localparam int LANES  = 4;
  localparam int LANE_W = 2;
  localparam int WORD_W = NIB_W * LANES;

  localparam logic [WORD_W-1:0] Y_RST = '0;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;
endpackage

// File: rtl/nibble_demux_acc_if.sv
// Nibble-in / word-out handshake bundle.
// master drives nibbles and takes words; slave is the accumulator.
interface nibble_demux_acc_if;
  import nibble_demux_pkg::*;

  logic [NIB_W-1:0]  d;
  logic              s;
  logic              a;
  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] Y;
  logic              out_valid;
  logic              out_ready;
  logic [LANES-1:0]  lane_mask;
  logic              dup_err;

  modport master (
    output d, s, a, mode, in_valid, out_ready,
    input  in_ready, Y, out_valid, lane_mask, dup_err
  );

  modport slave (
    input  d, s, a, mode, in_valid, out_ready,
    output in_ready, Y, out_valid, lane_mask, dup_err
  );
endinterface

// File: rtl/demux_dec2to4.sv
// One-hot lane strobe decoder.
// Drives both the word lane enables and the mask set bits.
module demux_dec2to4
  import nibble_demux_pkg::*;
(
  input  logic [LANE_W-1:0] idx,
  input  logic              en,
  output logic [LANES-1:0]  strb
);

  // one strobe per lane, all low when not enabled
  always_comb begin
    strb = '0;
    if (en) begin
      strb[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/nibble_demux_acc.sv
// Nibble demux accumulator: routes nibbles into word lanes,
// then holds the full word under a valid/ready handshake.
module nibble_demux_acc
  import nibble_demux_pkg::*;
(
  input logic              clk,
  input logic              rst,
  nibble_demux_acc_if.slave bus
);

  state_e            state_q, state_d;
  logic [LANE_W-1:0] ptr_q, ptr_d;
  logic              mode_q, mode_d;
  logic [WORD_W-1:0] y_q, y_d;
  logic [LANES-1:0]  mask_q, mask_d;
  logic              dup_q, dup_d;
  logic              ov_q, ov_d;
  logic              ir_q, ir_d;

  logic              first;
  logic              eff_mode;
  logic [LANE_W-1:0] lane;
  logic              acc;
  logic [LANES-1:0]  strb;

  // live mode applies to the first nibble, latched mode afterwards
  always_comb begin
    first    = (mask_q == '0);
    eff_mode = first ? bus.mode : mode_q;
    lane     = eff_mode ? ptr_q : {bus.s, bus.a};
    acc      = bus.in_valid && ir_q && (state_q == FILL);
  end

  demux_dec2to4 u_dec (
    .idx  (lane),
    .en   (acc),
    .strb (strb)
  );

  // next-state: lane writes in FILL, word release in HOLD
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mode_d  = mode_q;
    y_d     = y_q;
    mask_d  = mask_q;
    dup_d   = 1'b0;
    ov_d    = ov_q;
    ir_d    = ir_q;
    case (state_q)
      FILL: begin
        if (acc) begin
          for (int k = 0; k < LANES; k++) begin
            if (strb[k]) begin
              y_d[k*NIB_W +: NIB_W] = bus.d;
            end
          end
          mask_d = mask_q | strb;
          if (first) begin
            mode_d = bus.mode;
          end
          if (eff_mode) begin
            ptr_d = ptr_q + 1'b1;
          end
          dup_d = !eff_mode && |(strb & mask_q);
          if (&(mask_q | strb)) begin
            state_d = HOLD;
            ov_d    = 1'b1;
            ir_d    = 1'b0;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = FILL;
          mask_d  = '0;
          ptr_d   = '0;
          ov_d    = 1'b0;
          ir_d    = 1'b1;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // all state and outputs registered; rst discards any partial word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      ptr_q   <= '0;
      mode_q  <= 1'b0;
      y_q     <= Y_RST;
      mask_q  <= '0;
      dup_q   <= 1'b0;
      ov_q    <= 1'b0;
      ir_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mode_q  <= mode_d;
      y_q     <= y_d;
      mask_q  <= mask_d;
      dup_q   <= dup_d;
      ov_q    <= ov_d;
      ir_q    <= ir_d;
    end
  end

  assign bus.Y         = y_q;
  assign bus.lane_mask = mask_q;
  assign bus.out_valid = ov_q;
  assign bus.in_ready  = ir_q;
  assign bus.dup_err   = dup_q;

endmodule

// File: tb/tb_nibble_demux_acc.sv
// Directed bench for nibble_demux_acc.
// Each scenario task drives vectors and checks hand-computed values.
module tb_nibble_demux_acc;
  import nibble_demux_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  nibble_demux_acc_if bus ();

  nibble_demux_acc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (bus.Y !== 16'h0000 || bus.lane_mask !== 4'b0000 ||
        bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.dup_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: Y=%h mask=%b ov=%b ir=%b dup=%b want 0000 0000 0 1 0",
               bus.Y, bus.lane_mask, bus.out_valid, bus.in_ready, bus.dup_err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_seq_fill();
    logic [3:0] dv [9] = '{4'hB, 4'h1, 4'hC, 4'h0, 4'h2, 4'h2, 4'h3, 4'h4, 4'h5};
    logic       ov [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic [3:0] mk [9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000,
                           4'b0001, 4'b0011, 4'b0111, 4'b1111};
    bus.mode      = 1'b1;
    bus.s         = 1'b1;
    bus.a         = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.d = dv[i];
      tick();
      checks++;
      if (bus.out_valid !== ov[i] || bus.lane_mask !== mk[i]) begin
        errors++;
        $display("FAIL seq_cadence[%0d]: ov=%b mask=%b want ov=%b mask=%b",
                 i, bus.out_valid, bus.lane_mask, ov[i], mk[i]);
      end
      if (i == 3 || i == 4) begin
        checks++;
        if (bus.Y !== 16'h0C1B) begin
          errors++;
          $display("FAIL seq_word1[%0d]: Y=%h want 0c1b", i, bus.Y);
        end
      end
    end
    checks++;
    if (bus.Y !== 16'h5432 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL seq_word2: Y=%h ir=%b want 5432 0", bus.Y, bus.in_ready);
    end
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL seq_take: ov=%b ir=%b want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_addressed();
    logic [1:0] sa [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [3:0] dv [4] = '{4'hB, 4'h1, 4'hC, 4'h0};
    logic [3:0] mk [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    do_reset();
    bus.mode      = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {bus.s, bus.a} = sa[i];
      bus.d = dv[i];
      tick();
      checks++;
      if (bus.lane_mask !== mk[i] || bus.dup_err !== 1'b0) begin
        errors++;
        $display("FAIL addr_mask[%0d]: mask=%b dup=%b want %b 0",
                 i, bus.lane_mask, bus.dup_err, mk[i]);
      end
    end
    checks++;
    if (bus.Y !== 16'h0C1B || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL addr_word: Y=%h ov=%b want 0c1b 1", bus.Y, bus.out_valid);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_dup();
    bus.mode     = 1'b0;
    bus.in_valid = 1'b1;
    {bus.s, bus.a} = 2'b01;
    bus.d = 4'h1;
    tick();
    checks++;
    if (bus.lane_mask !== 4'b0010 || bus.dup_err !== 1'b0) begin
      errors++;
      $display("FAIL dup_first: mask=%b dup=%b want 0010 0", bus.lane_mask, bus.dup_err);
    end
    bus.d = 4'h7;
    tick();
    checks++;
    if (bus.Y !== 16'h0C7B || bus.dup_err !== 1'b1 || bus.lane_mask !== 4'b0010) begin
      errors++;
      $display("FAIL dup_second: Y=%h dup=%b mask=%b want 0c7b 1 0010",
               bus.Y, bus.dup_err, bus.lane_mask);
    end
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.dup_err !== 1'b0 || bus.Y !== 16'h0C7B) begin
      errors++;
      $display("FAIL dup_pulse: dup=%b Y=%h want 0 0c7b", bus.dup_err, bus.Y);
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    do_reset();
    bus.mode      = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.d = 4'(i + 1);
      tick();
    end
    checks++;
    if (bus.Y !== 16'h4321 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_word: Y=%h ov=%b want 4321 1", bus.Y, bus.out_valid);
    end
    bus.mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.d = (i % 2 == 0) ? 4'hF : 4'hA;
      {bus.s, bus.a} = 2'(i);
      tick();
      ok = (bus.Y === 16'h4321) && (bus.in_ready === 1'b0) &&
           (bus.out_valid === 1'b1) && (bus.lane_mask === 4'b1111) &&
           (bus.dup_err === 1'b0);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL bp_hold[%0d]: Y=%h ir=%b ov=%b mask=%b dup=%b want 4321 0 1 1111 0",
                 i, bus.Y, bus.in_ready, bus.out_valid, bus.lane_mask, bus.dup_err);
      end
    end
    bus.mode      = 1'b1;
    bus.out_ready = 1'b1;
    bus.d         = 4'h9;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.lane_mask !== 4'b0000 || bus.Y !== 16'h4321) begin
      errors++;
      $display("FAIL bp_release: ov=%b ir=%b mask=%b Y=%h want 0 1 0000 4321",
               bus.out_valid, bus.in_ready, bus.lane_mask, bus.Y);
    end
    tick();
    checks++;
    if (bus.Y !== 16'h4329 || bus.lane_mask !== 4'b0001) begin
      errors++;
      $display("FAIL bp_next: Y=%h mask=%b want 4329 0001", bus.Y, bus.lane_mask);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_mode_change();
    do_reset();
    bus.mode     = 1'b1;
    bus.in_valid = 1'b1;
    bus.d = 4'hA;
    tick();
    bus.d = 4'hB;
    tick();
    bus.mode = 1'b0;
    {bus.s, bus.a} = 2'b00;
    bus.d = 4'hC;
    tick();
    checks++;
    if (bus.Y !== 16'h0CBA || bus.lane_mask !== 4'b0111 || bus.dup_err !== 1'b0) begin
      errors++;
      $display("FAIL mode_change: Y=%h mask=%b dup=%b want 0cba 0111 0",
               bus.Y, bus.lane_mask, bus.dup_err);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.mode     = 1'b1;
    bus.in_valid = 1'b1;
    bus.d = 4'h5;
    tick();
    bus.d = 4'h6;
    tick();
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.Y !== 16'h0000 || bus.lane_mask !== 4'b0000 ||
        bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: Y=%h mask=%b ov=%b ir=%b want 0000 0000 0 1",
               bus.Y, bus.lane_mask, bus.out_valid, bus.in_ready);
    end
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.d = 4'h3;
    tick();
    checks++;
    if (bus.Y !== 16'h0003 || bus.lane_mask !== 4'b0001) begin
      errors++;
      $display("FAIL reset_restart: Y=%h mask=%b want 0003 0001", bus.Y, bus.lane_mask);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.d         = '0;
    bus.s         = 1'b0;
    bus.a         = 1'b0;
    bus.mode      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_seq_fill();
    test_addressed();
    test_dup();
    test_backpressure();
    test_mode_change();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_demux_acc.md
# nibble_demux_acc

Sequential counterpart of the 16-bit nibble multiplexer: it routes 4-bit nibbles into the lane of a 16-bit word selected by `{s,a}`, or by an internal pointer. When all four lanes hold fresh data it presents the word on `Y` and holds it under a valid/ready handshake. It sits on the write side of the nibble path: upstream logic produces nibbles, and the mux reads the assembled word back out.

## Interface
- `NIB_W`, 4: nibble width.
- `LANES`, 4: lanes per word; `Y` width = `NIB_W*LANES` = 16.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `d` in 4: nibble data.
- `s` in 1: lane select, MSB.
- `a` in 1: lane select, LSB.
- `mode` in 1: 0 = addressed (lane = `{s,a}`), 1 = sequential (lane = internal pointer).
- `in_valid` in 1: nibble offered.
- `in_ready` out 1: block accepts a nibble this cycle.
- `Y` out 16: assembled word; lane k = `Y[4k+3:4k]`.
- `out_valid` out 1: `Y` complete and stable.
- `out_ready` in 1: consumer takes `Y`.
- `lane_mask` out 4: lanes written since the last word was taken.
- `dup_err` out 1: one-cycle pulse when an addressed write hits an already-written lane.

## Operation
- Reset values: `Y`=16'h0000, `lane_mask`=4'b0000, `out_valid`=0, `in_ready`=1, `dup_err`=0, pointer=0, state=FILL.
- Accept: `in_valid && in_ready` at a rising edge.
- FSM states: FILL, HOLD.
- FILL: `in_ready`=1. On accept:
  - the target lane of `Y` gets `d`;
  - its `lane_mask` bit is set;
  - other lanes keep their previous contents.
- Mode latch: `mode` is latched on the first accept of a word (`lane_mask`==0), using the live value for that nibble. Toggling `mode` while `lane_mask`≠0 has no effect until the next word.
- Sequential mode:
  - lane = pointer; pointer increments by 1 per accept.
  - pointer wraps 3→0 and is cleared on leaving HOLD.
  - `s` and `a` are ignored.
- Addressed mode, duplicate lane:
  - the lane is overwritten with the new nibble;
  - `dup_err` pulses for exactly one cycle;
  - `lane_mask` is unchanged.
- FILL→HOLD: taken on the edge where the accept makes `lane_mask`==4'b1111.
- HOLD:
  - `out_valid`=1, `in_ready`=0;
  - `Y` is frozen;
  - `in_valid` is ignored and no `dup_err` is raised.
- HOLD→FILL: taken on the edge where `out_ready` is 1.
  - `lane_mask` and pointer clear to 0; `out_valid` clears.
  - `Y` keeps the taken word until overwritten lane by lane.
- `rst` mid-word or in HOLD: all state returns immediately to reset values, and the partial word is discarded.

## Timing
- All outputs are registered, changing only on the rising `clk` edge or on asynchronous `rst`.
- Nibble write: lane data and mask bit are visible the cycle after the accept edge.
- Word latency: fourth accept on edge N → `out_valid`=1 and `in_ready`=0 from edge N onward.
- Output handshake: `out_valid && out_ready` on edge M → `out_valid`=0 and `in_ready`=1 after edge M. No nibble is accepted on edge M.
- Throughput: with `out_ready` tied high and `in_valid` continuous, one word per 5 cycles (4 accepts plus 1 HOLD).
- `dup_err` is high in the cycle after the offending accept edge and low the cycle after that.

## Structure
- Shared package `nibble_demux_pkg` holds:
  - `NIB_W`, `LANES`;
  - the lane-index width (2);
  - the state enum {FILL, HOLD};
  - the reset constant for `Y`.
- Sub-module `demux_dec2to4`: combinational 2-to-4 one-hot decoder.
  - Input: lane index plus enable.
  - Output: lane write strobes.
  - It is reused for the `Y` lane enables and the `lane_mask` set bits.
- Top-level contents: FSM, pointer, mode latch, 16-bit word register, `dup_err` register.

## Test plan
- Sequential fill: `mode`=1; `d`=B,1,C,0 on four consecutive cycles; `out_ready`=1 → after the fourth edge `Y`=16'h0C1B, `out_valid` high for 1 cycle, 5-cycle cadence on repeat.
- Addressed fill: `mode`=0; `{s,a}`=00,01,10,11 with `d`=B,1,C,0 → `Y`=16'h0C1B; `lane_mask` goes 0001, 0011, 0111, 1111.
- Duplicate write: `mode`=0; `{s,a}`=01 with `d`=1, then 01 with `d`=7 → lane1=7; `dup_err` pulses once; `lane_mask`=0010.
- Backpressure: word complete, `out_ready`=0 for 10 cycles with `in_valid`=1 and `d` toggling → `Y` stable, `in_ready`=0, no lane changes; `out_ready`=1 → `out_valid` drops, next word is accepted.
- Mode change mid-word: start `mode`=1 with two nibbles, then set `mode`=0 with `{s,a}`=00 → the third nibble still lands in lane2.
- Reset mid-word: assert `rst` asynchronously after two nibbles → `Y`=0, `lane_mask`=0, `out_valid`=0, `in_ready`=1 immediately; the next sequential fill starts at lane0.
